// File: rtl/sram_ctrl.sv
// Drives a 512K x 8 asynchronous SRAM from a 32-bit single-outstanding strobe/ack bus,
// splitting each word access into byte cycles with parameterised OE/WE timing.
module sram_ctrl #(
  parameter int unsigned RD_CYCLES = 2,
  parameter int unsigned WE_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [16:0] bus_addr,
  input  logic [31:0] bus_wrdata,
  input  logic [3:0]  bus_bytesel,
  input  logic        bus_wren,
  input  logic        bus_strobe,
  output logic        bus_busy,
  output logic        bus_ack,
  output logic [31:0] bus_rddata,
  output logic [18:0] sram_a,
  inout  wire  [7:0]  sram_dq,
  output logic        sram_ce_n,
  output logic        sram_oe_n,
  output logic        sram_we_n
);

  localparam int unsigned MAX_CYC = (RD_CYCLES > WE_CYCLES) ? RD_CYCLES : WE_CYCLES;
  localparam int unsigned CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(RD_CYCLES - 1);
  localparam logic [CNT_W-1:0] WE_LAST = CNT_W'(WE_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_RD       = 3'd1,
    S_WR_SETUP = 3'd2,
    S_WR_PULSE = 3'd3,
    S_WR_HOLD  = 3'd4,
    S_DONE     = 3'd5
  } state_e;

  state_e            state_q, state_d;
  logic [1:0]        lane_q, lane_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [16:0]       addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [3:0]        mask_q, mask_d;
  logic [3:0]        mask_left;
  logic [23:0]       rd_buf_q, rd_buf_d;
  logic [31:0]       rddata_q, rddata_d;

  logic              busy_q, busy_d;
  logic              ack_q, ack_d;
  logic              ce_n_q, ce_n_d;
  logic              oe_n_q, oe_n_d;
  logic              we_n_q, we_n_d;
  logic [18:0]       a_q, a_d;
  logic              dq_oe_q, dq_oe_d;
  logic [7:0]        dq_out_q, dq_out_d;

  function automatic logic [1:0] lowest_lane(input logic [3:0] m);
    if (m[0])      return 2'd0;
    else if (m[1]) return 2'd1;
    else if (m[2]) return 2'd2;
    else           return 2'd3;
  endfunction

  function automatic logic [7:0] lane_byte(input logic [31:0] w, input logic [1:0] l);
    unique case (l)
      2'd0:    return w[7:0];
      2'd1:    return w[15:8];
      2'd2:    return w[23:16];
      default: return w[31:24];
    endcase
  endfunction

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      lane_q   <= 2'd0;
      cnt_q    <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      mask_q   <= '0;
      rd_buf_q <= '0;
      rddata_q <= '0;
      busy_q   <= 1'b0;
      ack_q    <= 1'b0;
      ce_n_q   <= 1'b1;
      oe_n_q   <= 1'b1;
      we_n_q   <= 1'b1;
      a_q      <= '0;
      dq_oe_q  <= 1'b0;
      dq_out_q <= '0;
    end else begin
      state_q  <= state_d;
      lane_q   <= lane_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      mask_q   <= mask_d;
      rd_buf_q <= rd_buf_d;
      rddata_q <= rddata_d;
      busy_q   <= busy_d;
      ack_q    <= ack_d;
      ce_n_q   <= ce_n_d;
      oe_n_q   <= oe_n_d;
      we_n_q   <= we_n_d;
      a_q      <= a_d;
      dq_oe_q  <= dq_oe_d;
      dq_out_q <= dq_out_d;
    end
  end

  // Next state, lane sequencing and read-data capture
  always_comb begin
    state_d   = state_q;
    lane_d    = lane_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    mask_d    = mask_q;
    mask_left = mask_q;
    rd_buf_d  = rd_buf_q;
    rddata_d  = rddata_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus_strobe) begin
          addr_d  = bus_addr;
          wdata_d = bus_wrdata;
          cnt_d   = '0;
          if (!bus_wren) begin
            state_d = S_RD;
            lane_d  = 2'd0;
            mask_d  = 4'hF;
          end else if (bus_bytesel == 4'h0) begin
            state_d = S_DONE;
            mask_d  = 4'h0;
          end else begin
            state_d = S_WR_SETUP;
            mask_d  = bus_bytesel;
            lane_d  = lowest_lane(bus_bytesel);
          end
        end
      end
      S_RD: begin
        if (cnt_q == RD_LAST) begin
          cnt_d = '0;
          unique case (lane_q)
            2'd0: rd_buf_d[7:0]   = sram_dq;
            2'd1: rd_buf_d[15:8]  = sram_dq;
            2'd2: rd_buf_d[23:16] = sram_dq;
            default: rddata_d     = {sram_dq, rd_buf_q};
          endcase
          if (lane_q == 2'd3) state_d = S_DONE;
          else                lane_d  = lane_q + 2'd1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_WR_SETUP: begin
        state_d = S_WR_PULSE;
        cnt_d   = '0;
      end
      S_WR_PULSE: begin
        if (cnt_q == WE_LAST) state_d = S_WR_HOLD;
        else                  cnt_d   = cnt_q + CNT_W'(1);
      end
      S_WR_HOLD: begin
        // Retire the finished lane; disabled lanes are skipped without spending a cycle
        mask_left = mask_q & ~4'(4'b0001 << lane_q);
        mask_d    = mask_left;
        if (mask_left != 4'h0) begin
          state_d = S_WR_SETUP;
          lane_d  = lowest_lane(mask_left);
        end else begin
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Registered outputs decoded from the upcoming state
  always_comb begin
    busy_d   = (state_d != S_IDLE);
    ack_d    = (state_d == S_DONE);
    ce_n_d   = 1'b1;
    oe_n_d   = 1'b1;
    we_n_d   = 1'b1;
    a_d      = a_q;
    dq_oe_d  = 1'b0;
    dq_out_d = dq_out_q;
    unique case (state_d)
      S_RD: begin
        ce_n_d = 1'b0;
        oe_n_d = 1'b0;
        a_d    = {addr_d, lane_d};
      end
      S_WR_SETUP, S_WR_PULSE, S_WR_HOLD: begin
        ce_n_d   = 1'b0;
        we_n_d   = (state_d != S_WR_PULSE);
        a_d      = {addr_d, lane_d};
        dq_oe_d  = 1'b1;
        dq_out_d = lane_byte(wdata_d, lane_d);
      end
      default: ;
    endcase
  end

  assign bus_busy   = busy_q;
  assign bus_ack    = ack_q;
  assign bus_rddata = rddata_q;
  assign sram_a     = a_q;
  assign sram_ce_n  = ce_n_q;
  assign sram_oe_n  = oe_n_q;
  assign sram_we_n  = we_n_q;
  assign sram_dq    = dq_oe_q ? dq_out_q : 8'bz;

endmodule
